// File: rtl/dsp_iq_pkg.sv
// Shared IQ-path definitions: coefficient format constants and the
// coefficient-update state encoding used by dsp_iq_corr and its neighbours.
package dsp_iq_pkg;

    localparam int unsigned COEF_BITS_DEF = 16;
    localparam int unsigned COEF_FRAC     = COEF_BITS_DEF - 2;
    localparam logic [COEF_BITS_DEF-1:0] COEF_ONE = (COEF_BITS_DEF)'(1) << COEF_FRAC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } iq_state_e;

endpackage

// File: rtl/dsp_round_sat.sv
// Round half-up, arithmetic shift right, then clamp (SAT_EN=1) or wrap
// (SAT_EN=0) to OUT_W bits. o_sat flags a clamped result.
module dsp_round_sat #(
    parameter int unsigned IN_W   = 29,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned SHIFT  = 14,
    parameter bit          SAT_EN = 1'b0
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic        [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] w_bias;
    logic signed [IN_W:0] w_shift;

    // One guard bit so the rounding add can never overflow
    assign w_bias  = $signed({i_data[IN_W-1], i_data}) + RND;
    assign w_shift = w_bias >>> SHIFT;

    // Reduce to output width: clamp when enabled, otherwise keep low bits
    always_comb begin
        o_data = w_shift[OUT_W-1:0];
        o_sat  = 1'b0;
        if (SAT_EN) begin
            if (w_shift > MAX_V) begin
                o_data = MAX_V[OUT_W-1:0];
                o_sat  = 1'b1;
            end else if (w_shift < MIN_V) begin
                o_data = MIN_V[OUT_W-1:0];
                o_sat  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_iq_corr.sv
// IQ imbalance correction: I passes through, Q <= Q*gain + I*phase.
// Three-stage pipeline, coefficients swapped atomically on a sample boundary.
// Build option: DSP_IQ_CORR_SAT_EN enables clamping and the sat_cnt counter.
module dsp_iq_corr
    import dsp_iq_pkg::*;
#(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned COEF_BITS = COEF_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_iq_corr_en,
    input  logic [COEF_BITS-1:0]   cfg_gain,
    input  logic [COEF_BITS-1:0]   cfg_phase,
    input  logic                   cfg_wr,
    output logic                   cfg_busy,
    output logic                   cfg_ack,
    input  logic [2*WIDTH-1:0]     in_data,
    input  logic                   in_valid,
    output logic [2*WIDTH-1:0]     out_data,
    output logic                   out_valid,
    output logic [15:0]            sat_cnt
);

    localparam int unsigned PW   = WIDTH + COEF_BITS;
    localparam int unsigned SW   = PW + 1;
    localparam int unsigned FRAC = COEF_BITS - 2;
    localparam logic [COEF_BITS-1:0] UNITY = (COEF_BITS)'(1) << FRAC;
`ifdef DSP_IQ_CORR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    iq_state_e              r_state;
    logic [COEF_BITS-1:0]   r_shd_gain, r_shd_phase;
    logic [COEF_BITS-1:0]   r_act_gain, r_act_phase;

    logic signed [WIDTH-1:0]     r1_i, r1_q;
    logic signed [COEF_BITS-1:0] r1_gain, r1_phase;
    logic                        r1_vld, r1_en;
    logic signed [PW-1:0]        r2_prod_q, r2_prod_i;
    logic [WIDTH-1:0]            r2_i, r2_q;
    logic                        r2_vld, r2_en;

    logic signed [SW-1:0]        w_sum;
    logic [WIDTH-1:0]            w_q;
    logic                        w_sat;

    // Coefficient shadow/active handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shd_gain  <= '0;
            r_shd_phase <= '0;
            r_act_gain  <= UNITY;
            r_act_phase <= '0;
            cfg_busy    <= 1'b0;
            cfg_ack     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    cfg_ack <= 1'b0;
                    if (cfg_wr) begin
                        r_shd_gain  <= cfg_gain;
                        r_shd_phase <= cfg_phase;
                        cfg_busy    <= 1'b1;
                        r_state     <= PENDING;
                    end
                end
                PENDING: begin
                    if (in_valid || !cfg_iq_corr_en) begin
                        r_act_gain  <= r_shd_gain;
                        r_act_phase <= r_shd_phase;
                        cfg_busy    <= 1'b0;
                        cfg_ack     <= 1'b1;
                        r_state     <= APPLY;
                    end
                end
                APPLY: begin
                    cfg_ack <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    cfg_busy <= 1'b0;
                    cfg_ack  <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // S1: sample plus the coefficients it will use; S2: products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_i      <= '0;
            r1_q      <= '0;
            r1_gain   <= '0;
            r1_phase  <= '0;
            r1_vld    <= 1'b0;
            r1_en     <= 1'b0;
            r2_prod_q <= '0;
            r2_prod_i <= '0;
            r2_i      <= '0;
            r2_q      <= '0;
            r2_vld    <= 1'b0;
            r2_en     <= 1'b0;
        end else begin
            r1_i      <= in_data[WIDTH-1:0];
            r1_q      <= in_data[2*WIDTH-1:WIDTH];
            r1_gain   <= r_act_gain;
            r1_phase  <= r_act_phase;
            r1_vld    <= in_valid;
            r1_en     <= cfg_iq_corr_en;
            r2_prod_q <= PW'(r1_q) * PW'(r1_gain);
            r2_prod_i <= PW'(r1_i) * PW'(r1_phase);
            r2_i      <= r1_i;
            r2_q      <= r1_q;
            r2_vld    <= r1_vld;
            r2_en     <= r1_en;
        end
    end

    assign w_sum = SW'(r2_prod_q) + SW'(r2_prod_i);

    dsp_round_sat #(
        .IN_W   (SW),
        .OUT_W  (WIDTH),
        .SHIFT  (FRAC),
        .SAT_EN (SAT_EN)
    ) u_round_sat (
        .i_data (w_sum),
        .o_data (w_q),
        .o_sat  (w_sat)
    );

    // S3: corrected or bypassed output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= r2_en ? {w_q, r2_i} : {r2_q, r2_i};
            out_valid <= r2_vld;
        end
    end

    // Saturation event counter, cleared when new coefficients take effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (r_state == APPLY) begin
            sat_cnt <= '0;
        end else if (SAT_EN && r2_vld && r2_en && w_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dsp_iq_corr.sv
// Directed bench for dsp_iq_corr with a queue scoreboard and a separate monitor.
module tb_dsp_iq_corr;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned CB    = 16;

`ifdef DSP_IQ_CORR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_iq_corr_en;
    logic [CB-1:0]     cfg_gain, cfg_phase;
    logic              cfg_wr;
    logic              cfg_busy, cfg_ack;
    logic [2*WIDTH-1:0] in_data;
    logic              in_valid;
    logic [2*WIDTH-1:0] out_data;
    logic              out_valid;
    logic [15:0]       sat_cnt;

    typedef struct {
        logic [2*WIDTH-1:0] data;
        int                 cyc;
        string              name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    dsp_iq_corr #(.WIDTH(WIDTH), .COEF_BITS(CB)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_iq_corr_en (cfg_iq_corr_en),
        .cfg_gain       (cfg_gain),
        .cfg_phase      (cfg_phase),
        .cfg_wr         (cfg_wr),
        .cfg_busy       (cfg_busy),
        .cfg_ack        (cfg_ack),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .sat_cnt        (sat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*WIDTH-1:0] pk(input int q, input int i);
        logic [WIDTH-1:0] qq, ii;
        qq = 12'(q);
        ii = 12'(i);
        return {qq, ii};
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one valid sample and push its expected output
    task automatic send(input string nm, input int i, input int q, input int ei, input int eq);
        exp_t e;
        in_data  = pk(q, i);
        in_valid = 1'b1;
        e.data = pk(eq, ei);
        e.cyc  = cyc + 3;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge; single-cycle strobes drop
    task automatic step();
        @(negedge clk);
        in_valid = 1'b0;
        cfg_wr   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            step();
            k++;
        end
        check({nm, "_drain_pending"}, sb.size(), 0);
    endtask

    // Program coefficients, forcing the swap with a one-cycle bypass
    task automatic prog(input int g, input int p);
        bit seen;
        step();
        cfg_wr    = 1'b1;
        cfg_gain  = 16'(g);
        cfg_phase = 16'(p);
        step();
        cfg_iq_corr_en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (cfg_ack) seen = 1'b1;
        end
        cfg_iq_corr_en = 1'b1;
        check("prog_ack_seen", seen, 1);
    endtask

    // Monitor: pop and compare whenever the DUT presents a sample
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_data, 0);
                n_fail += (out_data == 0) ? 1 : 0;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, out_data, e.data);
                check({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_ack;
        rst = 1'b1;
        cfg_iq_corr_en = 1'b1;
        cfg_gain = '0;
        cfg_phase = '0;
        cfg_wr = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_ack", cfg_ack, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        rst = 1'b0;
        step();

        // Unity gain, zero phase at reset
        send("unity", 100, -200, 100, -200);
        step();
        drain("unity");

        // Swap under continuous valid
        cfg_wr = 1'b1; cfg_gain = 16'd8192; cfg_phase = 16'd0;
        send("swapA", 100, -200, 100, -200);
        step();
        check("swap_busy", cfg_busy, 1);
        check("swap_ack_early", cfg_ack, 0);
        send("swapB_old", 100, -200, 100, -200);
        step();
        check("swap_ack", cfg_ack, 1);
        check("swap_busy_clr", cfg_busy, 0);
        send("swapC_new", 100, -200, 100, -100);
        step();
        check("swap_ack_pulse", cfg_ack, 0);
        send("swapD_new", 100, -200, 100, -100);
        step();
        drain("swap");

        // Phase cross term and half-up rounding
        prog(16384, 1638);
        send("phase", 1000, 0, 1000, 100);
        step();
        prog(16384, 8192);
        send("rnd_pos", 5, 0, 5, 3);
        step();
        send("rnd_neg", -5, 0, -5, -2);
        step();
        drain("round");

        // Overflow: clamp or wrap
        prog(32767, 0);
        send("ovf_pos", 0, 2047, 0, SAT ? 2047 : -2);
        step();
        send("ovf_pos2", 0, 2047, 0, SAT ? 2047 : -2);
        step();
        send("ovf_neg", 0, -2048, 0, SAT ? -2048 : 0);
        step();
        drain("ovf");
        check("sat_cnt_ovf", sat_cnt, SAT ? 3 : 0);

        // Bypass: unchanged data, no saturation counting
        cfg_iq_corr_en = 1'b0;
        send("bypass", 123, 2047, 123, 2047);
        step();
        cfg_iq_corr_en = 1'b1;
        drain("bypass");
        check("sat_cnt_bypass", sat_cnt, SAT ? 3 : 0);

        // Pending with no valid; second write while busy ignored
        cfg_wr = 1'b1; cfg_gain = 16'd8192; cfg_phase = 16'd0;
        any_ack = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (cfg_ack) any_ack = 1'b1;
            if (k == 10) begin
                cfg_wr = 1'b1; cfg_gain = 16'd4096; cfg_phase = 16'd0;
            end
        end
        check("pend_busy", cfg_busy, 1);
        check("pend_no_ack", any_ack, 0);
        send("pendE_old", 0, 400, 0, 800);
        step();
        check("pend_ack", cfg_ack, 1);
        send("pendF_first_wr", 0, 400, 0, 200);
        step();
        check("sat_cnt_clr", sat_cnt, 0);
        drain("pend");

        // Reset while pending with a sample in flight
        cfg_wr = 1'b1; cfg_gain = 16'd4096; cfg_phase = 16'd0;
        in_data = pk(100, 100);
        in_valid = 1'b1;
        step();
        check("pre_rst_busy", cfg_busy, 1);
        rst = 1'b1;
        step();
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_ack", cfg_ack, 0);
        check("mid_rst_sat_cnt", sat_cnt, 0);
        step();
        rst = 1'b0;
        any_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (cfg_ack || out_valid) any_ack = 1'b1;
        end
        check("post_rst_quiet", any_ack, 0);
        send("post_rst_unity", 7, -9, 7, -9);
        step();
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_iq_corr.md
# dsp_iq_corr

Quadrature-imbalance correction stage placed directly downstream of the DC-offset corrector in the RX sample path. It consumes DC-free I/Q pairs and applies a gain/phase correction to the Q rail: I passes through, and Q becomes Q·gain + I·phase. Coefficients are programmed through a shadow-register handshake and swapped atomically on a sample boundary. Output is a fixed-latency pipeline feeding the decimation/packing stages.

## Interface
- WIDTH, 12, sample width per rail, signed two's complement
- COEF_BITS, 16, coefficient width, signed Q2.(COEF_BITS-2); 1.0 = 2^(COEF_BITS-2)
- clk  in  1  sample clock; the block's only clock
- rst  in  1  reset, asynchronous, active-high
- cfg_iq_corr_en  in  1  0 = bypass (I/Q delayed unchanged, same latency)
- cfg_gain  in  COEF_BITS  Q-rail gain coefficient (shadow value)
- cfg_phase  in  COEF_BITS  I-into-Q cross coefficient (shadow value)
- cfg_wr  in  1  single-cycle pulse: capture cfg_gain/cfg_phase into shadow
- cfg_busy  out  1  update pending; further cfg_wr ignored
- cfg_ack  out  1  one-cycle pulse when the new coefficients become active
- in_data  in  2*WIDTH  [WIDTH-1:0] = I, [2*WIDTH-1:WIDTH] = Q
- in_valid  in  1  sample strobe; may be high every cycle or gapped
- out_data  out  2*WIDTH  corrected pair, same packing
- out_valid  out  1  in_valid delayed 3 cycles
- sat_cnt  out  16  saturation event count (macro-dependent)

## Operation
- Reset values: out_data 0, out_valid 0, cfg_busy 0, cfg_ack 0, sat_cnt 0, active gain = 2^(COEF_BITS-2), active phase = 0, FSM IDLE.
- Coefficient FSM:
  - IDLE: cfg_wr → latch shadow, go to PENDING, cfg_busy=1.
  - PENDING: on a cycle with in_valid=1, or with cfg_iq_corr_en=0, copy shadow → active at the end of that cycle, go to APPLY. The sample accepted in that cycle uses the old coefficients; the next sample uses the new ones.
  - APPLY: cfg_ack=1 for this cycle only, cfg_busy=0, return to IDLE.
  - cfg_wr in PENDING or APPLY is ignored.
  - cfg_wr coincident with in_valid in IDLE: the current sample is not the swap point; the swap occurs on the next in_valid.
- Arithmetic (corrected mode):
  - prodQ = Q·gain and prodI = I·phase, each WIDTH+COEF_BITS bits signed.
  - sum is WIDTH+COEF_BITS+1 bits.
  - Round half-up: add 2^(COEF_BITS-3), then arithmetic shift right by COEF_BITS-2.
  - Reduce to WIDTH bits per Configuration. I_out = I exactly.
- Bypass: out_data = in_data delayed 3 cycles. The FSM still runs; no saturation counting.
- Sample coefficients are captured with the data at stage 1, so a swap never splits a sample.
- Reset mid-pipeline clears all stages; any pending update is lost and the active coefficients return to unity/zero.

## Timing
- Pipeline advances every clock:
  - S1 registers I, Q, active gain and active phase.
  - S2 registers both products.
  - S3 registers the sum, rounding and saturation result into out_data.
- out_valid(t+3) = in_valid(t); out_data is meaningful only when out_valid=1.
- cfg_ack asserts 1 cycle after the swap cycle; cfg_busy deasserts in the same cycle as cfg_ack.
- With in_valid held low and enable high, PENDING persists indefinitely.

## Configuration
- DSP_IQ_CORR_SAT_EN defined:
  - Rounded result clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Each clamped valid output increments sat_cnt, which saturates at 0xFFFF.
  - sat_cnt clears on the APPLY cycle.
- Not defined: the result wraps (low WIDTH bits kept) and sat_cnt is tied to 0.

## Structure
- Shared package dsp_iq_pkg holds the following, which the DC-corrector consumers also use:
  - COEF_FRAC = COEF_BITS-2
  - COEF_ONE
  - FSM state enum (IDLE, PENDING, APPLY)
- Sub-module dsp_round_sat: parameterised round/shift/clamp with a sat flag output. It is instantiated once for the Q rail.

## Test plan
- Reset, then gain=16384, phase=0, I=100, Q=-200 → out I=100, Q=-200, out_valid exactly 3 cycles after in_valid.
- cfg_wr gain=8192 with continuous valid → cfg_busy=1. The swap-cycle sample still has Q unchanged; the next sample gives Q=-100; cfg_ack is a single pulse.
- phase=1638 (≈0.1), gain=16384, I=1000, Q=0 → Q_out=100. Verify round-half-up with I=5, phase=8192: 2.5 → 3.
- SAT_EN: gain=32767, Q=2047 → Q_out=2047, sat_cnt increments once per valid. Without the macro: wrapped value, sat_cnt=0.
- cfg_wr while in_valid is low for 50 cycles → swap waits for the first valid. A second cfg_wr while busy is ignored; the first values take effect.
- Assert rst while PENDING with samples in flight → all outputs 0 next cycle, active coefficients back to unity/zero, no cfg_ack.
